// File: rtl/systolic_seq.sv
// Sequencer for an N x N output-stationary systolic MAC array: operand address stream,
// skewed init wavefront and result-beat counting. Optional perf counters: SYSTOLIC_SEQ_PERF_EN.
module systolic_seq #(
    parameter int N      = 4,
    parameter int K_W    = 16,
    parameter int T_W    = 16,
    parameter int A_W    = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [K_W-1:0]    k_len,
    input  logic [T_W-1:0]    num_tiles,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [A_W-1:0]    rd_addr,
    output logic [2*N-2:0]    init_diag,
    input  logic [N-1:0]      res_valid
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_drain
`endif
);

    // state   | meaning
    // IDLE    | waiting for start
    // FEED    | streaming T*K operand reads, first tag on beat 0 of each tile
    // FLUSH   | one extra first tag to unload the last tile
    // DRAIN   | waiting for T*N*N counted result beats
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int CNT_W = T_W + 2 * $clog2(N) + 1;

    logic [1:0]       state_q, state_d;
    logic [K_W-1:0]   k_q, k_d, beat_q, beat_d;
    logic [T_W-1:0]   t_q, t_d, tile_q, tile_d;
    logic [A_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, pop, target;
    logic             seen_q, seen_d, cnt_en_q, cnt_en_d;
    logic             done_q, done_d, err_q, err_d;
    logic [RD_LAT-1:0] first_q;
    logic [2*N-3:0]   skew_q;
    logic             tag, init0, job_ok, accept;

    always_comb begin
        job_ok = (k_len >= K_W'(2 * N)) && (num_tiles != '0);
        accept = (state_q == S_IDLE) && start && job_ok;
        tag    = ((state_q == S_FEED) && (beat_q == '0)) || (state_q == S_FLUSH);
        init0  = first_q[RD_LAT-1];
        target = CNT_W'(t_q) * CNT_W'(N * N);
        pop    = '0;
        for (int j = 0; j < N; j++) pop = pop + CNT_W'(res_valid[j]);
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        t_d      = t_q;
        beat_d   = beat_q;
        tile_d   = tile_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        cnt_en_d = cnt_en_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        // The first wavefront unloads reset-state zeros; counting opens once the
        // second wavefront reaches the bottom PE of column 0.
        if (state_q != S_IDLE) begin
            if (skew_q[N-2]) begin
                if (!seen_q) seen_d = 1'b1;
                else         cnt_en_d = 1'b1;
            end
            if (cnt_en_q) cnt_d = cnt_q + pop;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    k_d      = k_len;
                    t_d      = num_tiles;
                    beat_d   = '0;
                    tile_d   = '0;
                    addr_d   = '0;
                    cnt_d    = '0;
                    seen_d   = 1'b0;
                    cnt_en_d = 1'b0;
                    state_d  = S_FEED;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            S_FEED: begin
                addr_d = addr_q + A_W'(1);
                if (beat_q == k_q - K_W'(1)) begin
                    beat_d = '0;
                    if (tile_q == t_q - T_W'(1)) state_d = S_FLUSH;
                    else                         tile_d  = tile_q + T_W'(1);
                end else begin
                    beat_d = beat_q + K_W'(1);
                end
            end
            S_FLUSH: state_d = S_DRAIN;
            default: begin
                if (cnt_d >= target) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            t_q      <= '0;
            beat_q   <= '0;
            tile_q   <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            cnt_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            first_q  <= '0;
            skew_q   <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            t_q      <= t_d;
            beat_q   <= beat_d;
            tile_q   <= tile_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            cnt_en_q <= cnt_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            first_q[0] <= tag;
            for (int i = 1; i < RD_LAT; i++) first_q[i] <= first_q[i-1];
            skew_q[0] <= init0;
            for (int i = 1; i < 2 * N - 2; i++) skew_q[i] <= skew_q[i-1];
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign rd_en     = (state_q == S_FEED);
    assign rd_addr   = addr_q;
    assign init_diag = {skew_q, init0};

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_drain_q;

    // Start-to-done distance: the accept cycle itself counts as one.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_drain_q  <= '0;
        end else if (accept) begin
            perf_cycles_q <= 32'd1;
            perf_drain_q  <= '0;
        end else begin
            if ((state_q != S_IDLE) && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
            if ((state_q == S_DRAIN) && (perf_drain_q != '1)) perf_drain_q <= perf_drain_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_drain  = perf_drain_q;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: behavioural column-unload model, scoreboard queues for
// addresses, init pulses and done timing; a second instance with a 4-bit address bus.
module tb_systolic_seq;
    localparam int N      = 4;
    localparam int K_W    = 16;
    localparam int T_W    = 16;
    localparam int A_W    = 16;
    localparam int RD_LAT = 1;
    localparam int D_W    = 2 * N - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [K_W-1:0] k_len = '0;
    logic [T_W-1:0] num_tiles = '0;
    logic           busy, done, err, rd_en;
    logic [A_W-1:0] rd_addr;
    logic [D_W-1:0] init_diag;
    logic           busy_w, done_w, err_w, rd_en_w;
    logic [3:0]     rd_addr_w;
    logic [D_W-1:0] init_diag_w;
    logic [N-1:0]   res_valid;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0]    perf_cycles, perf_drain, perf_cycles_w, perf_drain_w;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int col_cnt [N];
    int exp_addr [$];
    int exp_i0 [$];
    int exp_il [$];

    systolic_seq #(.N(N), .K_W(K_W), .T_W(T_W), .A_W(A_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .num_tiles(num_tiles),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
        .init_diag(init_diag), .res_valid(res_valid)
`ifdef SYSTOLIC_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_drain(perf_drain)
`endif
    );

    systolic_seq #(.N(N), .K_W(K_W), .T_W(T_W), .A_W(4), .RD_LAT(RD_LAT)) dut_w (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .num_tiles(num_tiles),
        .busy(busy_w), .done(done_w), .err(err_w), .rd_en(rd_en_w), .rd_addr(rd_addr_w),
        .init_diag(init_diag_w), .res_valid(res_valid)
`ifdef SYSTOLIC_SEQ_PERF_EN
        , .perf_cycles(perf_cycles_w), .perf_drain(perf_drain_w)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Column j unloads N sums through its bottom PE, starting the cycle after init reaches it.
    always @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (rst)                       col_cnt[j] <= 0;
            else if (init_diag[N-1+j])     col_cnt[j] <= N;
            else if (col_cnt[j] > 0)       col_cnt[j] <= col_cnt[j] - 1;
        end
    end

    always_comb begin
        res_valid = '0;
        for (int j = 0; j < N; j++) res_valid[j] = (col_cnt[j] != 0);
    end

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        k_len = K_W'(8);
        num_tiles = T_W'(1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, err, rd_en} !== 4'b0 || rd_addr !== '0 || init_diag !== '0) begin
            n_bad++;
            $display("FAIL reset_values: busy=%b done=%b err=%b rd_en=%b rd_addr=%0d init=%b want all 0",
                     busy, done, err, rd_en, rd_addr, init_diag);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || busy_w !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wins_over_start: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reject(input int k, input int t);
        @(negedge clk);
        start = 1'b1;
        k_len = K_W'(k);
        num_tiles = T_W'(t);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || err_w !== 1'b1) begin
            n_bad++;
            $display("FAIL reject_err k=%0d t=%0d: err=%b want 1", k, t, err);
        end
        n_cmp++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reject_idle k=%0d t=%0d: busy=%b rd_en=%b want 0 0", k, t, busy, rd_en);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (err !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
                n_bad++;
                $display("FAIL reject_after k=%0d t=%0d: err=%b busy=%b rd_en=%b want 0 0 0", k, t, err, busy, rd_en);
            end
        end
    endtask

    task automatic run_job(input int k, input int t, input int pulse_off, input int rst_off);
        int c, exp_done, a, p;
        logic [A_W-1:0] av;
        bit aborted, exp_busy, exp_rden;
        aborted = 1'b0;
        exp_addr.delete();
        exp_i0.delete();
        exp_il.delete();
        @(posedge clk);
        #1;
        c = cyc;
        start = 1'b1;
        k_len = K_W'(k);
        num_tiles = T_W'(t);
        for (int i = 0; i < t * k; i++) exp_addr.push_back(i);
        for (int i = 0; i <= t; i++) begin
            exp_i0.push_back(c + 1 + i * k + RD_LAT);
            exp_il.push_back(c + 1 + i * k + RD_LAT + 2 * N - 2);
        end
        exp_done = c + 1 + t * k + RD_LAT + 3 * N - 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!aborted && cyc < exp_done) begin
            @(negedge clk);
            if (pulse_off > 0 && cyc == c + pulse_off) begin
                start = 1'b1;
                k_len = K_W'(20);
            end else if (pulse_off > 0 && cyc == c + pulse_off + 1) begin
                start = 1'b0;
                k_len = K_W'(k);
            end
            if (rst_off > 0 && cyc == c + rst_off) begin
                rst = 1'b1;
                @(negedge clk);
                n_cmp++;
                if ({busy, done, err, rd_en} !== 4'b0 || rd_addr !== '0 || init_diag !== '0) begin
                    n_bad++;
                    $display("FAIL reset_abort: busy=%b done=%b err=%b rd_en=%b rd_addr=%0d init=%b want all 0",
                             busy, done, err, rd_en, rd_addr, init_diag);
                end
                rst = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
                        n_bad++;
                        $display("FAIL abort_quiet cyc=%0d: done=%b err=%b busy=%b want 0 0 0", cyc, done, err, busy);
                    end
                end
                aborted = 1'b1;
            end else begin
                exp_busy = (cyc > c) && (cyc < exp_done);
                exp_rden = (cyc > c) && (cyc <= c + t * k);
                n_cmp++;
                if (busy !== exp_busy) begin
                    n_bad++;
                    $display("FAIL busy cyc=%0d: got %b want %b", cyc - c, busy, exp_busy);
                end
                n_cmp++;
                if (done !== (cyc == exp_done)) begin
                    n_bad++;
                    $display("FAIL done cyc=%0d: got %b want %b", cyc - c, done, cyc == exp_done);
                end
                n_cmp++;
                if (err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL err_in_job cyc=%0d: got %b want 0", cyc - c, err);
                end
                n_cmp++;
                if (rd_en !== exp_rden) begin
                    n_bad++;
                    $display("FAIL rd_en cyc=%0d: got %b want %b", cyc - c, rd_en, exp_rden);
                end
                if (rd_en === 1'b1 && exp_addr.size() != 0) begin
                    a = exp_addr.pop_front();
                    av = A_W'(a);
                    n_cmp++;
                    if (rd_addr !== av) begin
                        n_bad++;
                        $display("FAIL rd_addr cyc=%0d: got %0d want %0d", cyc - c, rd_addr, av);
                    end
                    n_cmp++;
                    if (rd_addr_w !== av[3:0]) begin
                        n_bad++;
                        $display("FAIL rd_addr_wrap cyc=%0d: got %0d want %0d", cyc - c, rd_addr_w, av[3:0]);
                    end
                end
                if (init_diag[0] === 1'b1) begin
                    p = (exp_i0.size() != 0) ? exp_i0.pop_front() : -1;
                    n_cmp++;
                    if (cyc != p) begin
                        n_bad++;
                        $display("FAIL init_diag0 pulse: got cycle %0d want %0d", cyc - c, p - c);
                    end
                end
                if (init_diag[D_W-1] === 1'b1) begin
                    p = (exp_il.size() != 0) ? exp_il.pop_front() : -1;
                    n_cmp++;
                    if (cyc != p) begin
                        n_bad++;
                        $display("FAIL init_diag_last pulse: got cycle %0d want %0d", cyc - c, p - c);
                    end
                end
                n_cmp++;
                if (init_diag_w !== init_diag || done_w !== done || busy_w !== busy) begin
                    n_bad++;
                    $display("FAIL wrap_instance cyc=%0d: init=%b/%b done=%b/%b busy=%b/%b want equal",
                             cyc - c, init_diag_w, init_diag, done_w, done, busy_w, busy);
                end
            end
        end
        if (!aborted) begin
            n_cmp++;
            if (exp_addr.size() != 0 || exp_i0.size() != 0 || exp_il.size() != 0) begin
                n_bad++;
                $display("FAIL leftover_expected: addr=%0d i0=%0d il=%0d want 0 0 0",
                         exp_addr.size(), exp_i0.size(), exp_il.size());
            end
`ifdef SYSTOLIC_SEQ_PERF_EN
            n_cmp++;
            if (perf_cycles !== 32'(exp_done - c) || perf_drain !== 32'(exp_done - c - 2 - t * k)) begin
                n_bad++;
                $display("FAIL perf_at_done: cycles=%0d drain=%0d want %0d %0d",
                         perf_cycles, perf_drain, exp_done - c, exp_done - c - 2 - t * k);
            end
`endif
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                n_cmp++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL after_done: done=%b busy=%b want 0 0", done, busy);
                end
`ifdef SYSTOLIC_SEQ_PERF_EN
                n_cmp++;
                if (perf_cycles !== 32'(exp_done - c) || perf_drain !== 32'(exp_done - c - 2 - t * k)) begin
                    n_bad++;
                    $display("FAIL perf_hold: cycles=%0d drain=%0d want %0d %0d",
                             perf_cycles, perf_drain, exp_done - c, exp_done - c - 2 - t * k);
                end
`endif
            end
        end
    endtask

    task automatic test_single_tile();
        run_job(8, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_job(8, 3, 0, 0);
    endtask

    task automatic test_busy_reset();
        run_job(8, 2, 3, 2 * 8 + 4);
        run_job(8, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_reject(7, 1);
        test_reject(8, 0);
        test_single_tile();
        test_back_to_back();
        test_busy_reset();
        test_reject(2 * N - 1, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
